// File: rtl/timing_leak_monitor.sv
`default_nettype none
// ===================================================================
// timing_leak_monitor: per-channel start-to-done latency, skew, leak count
// Rev 1.0
// ===================================================================
module timing_leak_monitor #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [NUM_CH-1:0]         done,
  output logic                      busy,
  output logic                      timingLeakDone,
  output logic                      timingLeak,
  output logic                      timeout,
  output logic [NUM_CH*CNT_W-1:0]   latency,
  output logic [CNT_W-1:0]          skew,
  output logic [CNT_W-1:0]          leakCount
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_ONES    = '1;
  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);

  state_t                    r_state;
  logic [CNT_W-1:0]          r_cyc;
  logic [CNT_W-1:0]          r_min;
  logic [CNT_W-1:0]          r_max;
  logic [NUM_CH-1:0]         r_mask;
  logic [NUM_CH*CNT_W-1:0]   r_cap;

  logic [NUM_CH-1:0]         w_hit;
  logic [NUM_CH-1:0]         w_mask_nx;
  logic [NUM_CH*CNT_W-1:0]   w_cap_nx;
  logic [NUM_CH*CNT_W-1:0]   w_lat_to;
  logic [CNT_W-1:0]          w_min;
  logic [CNT_W-1:0]          w_max;
  logic [CNT_W-1:0]          w_cnt_inc;
  logic                      w_all;
  logic                      w_expired;

  assign busy           = (r_state != S_IDLE);
  assign timingLeakDone = (r_state == S_REPORT);

  // A done level already captured is masked off, so only its first RUN cycle counts.
  assign w_hit     = done & ~r_mask;
  assign w_mask_nx = r_mask | w_hit;
  assign w_all     = &w_mask_nx;
  assign w_expired = (r_cyc == C_TIMEOUT);
  assign w_cnt_inc = (leakCount == C_ONES) ? leakCount : leakCount + 1'b1;

  always_comb begin
    w_cap_nx = r_cap;
    w_lat_to = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_hit[i]) begin
        w_cap_nx[i*CNT_W +: CNT_W] = r_cyc;
      end
      w_lat_to[i*CNT_W +: CNT_W] = w_mask_nx[i] ? w_cap_nx[i*CNT_W +: CNT_W] : C_ONES;
    end
  end

  // All channels hitting in one cycle share the same cyc, so one compare suffices.
  always_comb begin
    w_min = r_min;
    w_max = r_max;
    if (|w_hit) begin
      if (r_cyc < r_min) w_min = r_cyc;
      if (r_cyc > r_max) w_max = r_cyc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cyc      <= '0;
      r_min      <= '0;
      r_max      <= '0;
      r_mask     <= '0;
      r_cap      <= '0;
      timingLeak <= 1'b0;
      timeout    <= 1'b0;
      latency    <= '0;
      skew       <= '0;
      leakCount  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_cyc   <= {{(CNT_W-1){1'b0}}, 1'b1};
            r_mask  <= '0;
            r_min   <= C_ONES;
            r_max   <= '0;
          end
        end
        S_RUN: begin
          r_mask <= w_mask_nx;
          r_cap  <= w_cap_nx;
          r_min  <= w_min;
          r_max  <= w_max;
          if (w_all) begin
            r_state    <= S_REPORT;
            latency    <= w_cap_nx;
            skew       <= w_max - w_min;
            timeout    <= 1'b0;
            timingLeak <= (w_max != w_min);
            if (w_max != w_min) leakCount <= w_cnt_inc;
          end else if (w_expired) begin
            r_state    <= S_REPORT;
            latency    <= w_lat_to;
            skew       <= C_ONES;
            timeout    <= 1'b1;
            timingLeak <= 1'b1;
            leakCount  <= w_cnt_inc;
          end else begin
            r_cyc <= r_cyc + 1'b1;
          end
        end
        S_REPORT: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_timing_leak_monitor.sv
`default_nettype none
// ===================================================================
// tb_timing_leak_monitor: directed trials against a trial-level model
// Rev 1.0
// ===================================================================
module tb_timing_leak_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [3:0]  done_a = '0, done_b = '0;
  logic        busy_a, tld_a, leak_a, to_a, busy_b, tld_b, leak_b, to_b;
  logic [63:0] latency_a;
  logic [15:0] skew_a, cnt_a;
  logic [15:0] latency_b;
  logic [3:0]  skew_b, cnt_b;

  always #5 clk = ~clk;

  timing_leak_monitor #(.NUM_CH(4), .CNT_W(16), .TIMEOUT(16)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .done(done_a),
    .busy(busy_a), .timingLeakDone(tld_a), .timingLeak(leak_a), .timeout(to_a),
    .latency(latency_a), .skew(skew_a), .leakCount(cnt_a)
  );

  timing_leak_monitor #(.NUM_CH(4), .CNT_W(4), .TIMEOUT(8)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .done(done_b),
    .busy(busy_b), .timingLeakDone(tld_b), .timingLeak(leak_b), .timeout(to_b),
    .latency(latency_b), .skew(skew_b), .leakCount(cnt_b)
  );

  // Model state per instance (0 = A, 1 = B).
  int  exp_busy [2];
  int  exp_tld  [2];
  int  exp_leak [2];
  int  exp_to   [2];
  int  exp_skew [2];
  int  exp_cnt  [2];
  int  exp_lat  [2][4];
  int  maxv     [2] = '{65535, 15};
  int  to_lim   [2] = '{16, 8};

  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc_n = 0;
  bit  chk_en = 1'b0;
  int  d;

  task automatic cmp(input string name, input longint act, input longint expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc_n);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      exp_busy[k] = 0; exp_tld[k] = 0; exp_leak[k] = 0; exp_to[k] = 0;
      exp_skew[k] = 0; exp_cnt[k] = 0;
      for (int i = 0; i < 4; i++) exp_lat[k][i] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("busy_a", busy_a, exp_busy[0]);
      cmp("tld_a",  tld_a,  exp_tld[0]);
      cmp("leak_a", leak_a, exp_leak[0]);
      cmp("to_a",   to_a,   exp_to[0]);
      cmp("skew_a", skew_a, exp_skew[0]);
      cmp("cnt_a",  cnt_a,  exp_cnt[0]);
      cmp("busy_b", busy_b, exp_busy[1]);
      cmp("tld_b",  tld_b,  exp_tld[1]);
      cmp("leak_b", leak_b, exp_leak[1]);
      cmp("to_b",   to_b,   exp_to[1]);
      cmp("skew_b", skew_b, exp_skew[1]);
      cmp("cnt_b",  cnt_b,  exp_cnt[1]);
      for (int i = 0; i < 4; i++) begin
        cmp($sformatf("lat_a[%0d]", i), latency_a[i*16 +: 16], exp_lat[0][i]);
        cmp($sformatf("lat_b[%0d]", i), latency_b[i*4 +: 4],   exp_lat[1][i]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic set_in(input int k, input logic s, input logic [3:0] dv);
    if (k == 0) begin start_a = s; done_a = dv; end
    else        begin start_b = s; done_b = dv; end
  endtask

  // One trial: da[i] = RUN cycle where channel i first raises done (0 = never),
  // held for 'hold' cycles. Returns the REPORT cycle offset from the start cycle.
  task automatic trial(input int k, input int d0, input int d1, input int d2, input int d3,
                       input int hold, input bit pre_done, input bit restart2,
                       input int rst_at, output int rep_delay);
    int da [4];
    int lim, len, mx, mn, st;
    bit all;
    logic [3:0] dv;
    da = '{d0, d1, d2, d3};
    lim = to_lim[k];
    all = 1'b1; mx = 0; mn = 1 << 30;
    for (int i = 0; i < 4; i++) begin
      if (da[i] == 0 || da[i] > lim) all = 1'b0;
      if (da[i] > mx) mx = da[i];
      if (da[i] < mn) mn = da[i];
    end
    len = all ? mx : lim;
    rep_delay = -1;

    set_in(k, 1'b1, pre_done ? 4'hF : 4'h0);
    tick();
    st = cyc_n;
    exp_busy[k] = 1;
    for (int j = 1; j <= len; j++) begin
      dv = '0;
      for (int i = 0; i < 4; i++)
        if (da[i] != 0 && j >= da[i] && j < da[i] + hold) dv[i] = 1'b1;
      set_in(k, restart2 && j == 2, dv);
      if (rst_at == j) begin
        rst = 1'b0;
        tick();
        model_reset();
        rst = 1'b1;
        set_in(k, 1'b0, 4'h0);
        return;
      end
      tick();
      if (j == len) begin
        exp_tld[k] = 1;
        if (all) begin
          for (int i = 0; i < 4; i++) exp_lat[k][i] = da[i];
          exp_leak[k] = (mx != mn) ? 1 : 0;
          exp_skew[k] = mx - mn;
          exp_to[k]   = 0;
        end else begin
          for (int i = 0; i < 4; i++)
            exp_lat[k][i] = (da[i] != 0 && da[i] <= len) ? da[i] : maxv[k];
          exp_leak[k] = 1;
          exp_skew[k] = maxv[k];
          exp_to[k]   = 1;
        end
        if (exp_leak[k] == 1 && exp_cnt[k] < maxv[k]) exp_cnt[k]++;
        if ((k == 0 && tld_a) || (k == 1 && tld_b)) rep_delay = cyc_n - st + 1;
      end
    end
    set_in(k, 1'b0, 4'h0);
    tick();
    exp_busy[k] = 0;
    exp_tld[k]  = 0;
  endtask

  initial begin
    model_reset();
    tick();
    tick();
    chk_en = 1'b1;
    rst = 1'b1;

    // Equal latencies
    trial(0, 5, 5, 5, 5, 100, 0, 0, 0, d);
    cmp("eq_delay", d, 6);
    cmp("eq_lat2", latency_a[32 +: 16], 5);
    cmp("eq_skew", skew_a, 0);
    cmp("eq_leak", leak_a, 0);
    cmp("eq_cnt",  cnt_a, 0);

    // Mismatch, twice
    trial(0, 5, 5, 7, 5, 100, 0, 0, 0, d);
    cmp("mm_lat2", latency_a[32 +: 16], 7);
    cmp("mm_skew", skew_a, 2);
    cmp("mm_leak", leak_a, 1);
    cmp("mm_cnt",  cnt_a, 1);
    trial(0, 5, 5, 7, 5, 100, 0, 0, 0, d);
    cmp("mm_cnt2", cnt_a, 2);

    // Timeout: channel 3 silent
    trial(0, 4, 4, 4, 0, 100, 0, 0, 0, d);
    cmp("to_delay", d, 17);
    cmp("to_flag", to_a, 1);
    cmp("to_skew", skew_a, 16'hFFFF);
    cmp("to_lat3", latency_a[48 +: 16], 16'hFFFF);
    cmp("to_lat0", latency_a[0 +: 16], 4);
    cmp("to_cnt",  cnt_a, 3);

    // Ignored inputs: done before start, restart at cyc 2, long done levels
    trial(0, 5, 5, 5, 5, 100, 1, 1, 0, d);
    cmp("ign_delay", d, 6);
    cmp("ign_lat0", latency_a[0 +: 16], 5);
    trial(0, 2, 3, 3, 8, 10, 0, 0, 0, d);
    cmp("hold_lat0", latency_a[0 +: 16], 2);
    cmp("hold_skew", skew_a, 6);

    // Reset mid-run then fresh trial
    trial(0, 6, 6, 6, 6, 100, 0, 0, 3, d);
    cmp("rst_busy", busy_a, 0);
    cmp("rst_cnt",  cnt_a, 0);
    cmp("rst_lat0", latency_a[0 +: 16], 0);
    trial(0, 6, 6, 6, 6, 100, 0, 0, 0, d);
    cmp("fresh_lat3", latency_a[48 +: 16], 6);
    cmp("fresh_cnt",  cnt_a, 0);

    // Saturation on the narrow instance, then all channels in the first RUN cycle
    for (int t = 0; t < 20; t++) trial(1, 1, 2, 2, 2, 100, 0, 0, 0, d);
    cmp("sat_cnt", cnt_b, 15);
    trial(1, 1, 1, 1, 1, 100, 0, 0, 0, d);
    cmp("one_delay", d, 2);
    cmp("one_lat2", latency_b[8 +: 4], 1);
    cmp("one_leak", leak_b, 0);
    cmp("one_cnt", cnt_b, 15);

    tick();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/timing_leak_monitor.md
# timing_leak_monitor

Parametrised N-channel timing-leak monitor for the constant-time multiplier verification harness. It observes the `productDone` outputs of `NUM_CH` multiplier copies that were all launched by a common `start`. For each channel it measures the start-to-done latency, flags any latency mismatch as a timing leak, and reports the skew. It also keeps a saturating count of leaking trials, so that long randomised runs can be judged from one counter.

## Interface
- `NUM_CH`, default 4: number of monitored multiplier copies (≥2).
- `CNT_W`, default 16: width of the cycle counter, latencies, skew and leak counter.
- `TIMEOUT`, default 1024: maximum RUN cycles before a trial is aborted (1 ≤ `TIMEOUT` < 2^`CNT_W`−1).

Ports:
- `clk`  input  1: sole clock; all logic is on the rising edge.
- `rst`  input  1: synchronous, active-low reset.
- `start`  input  1: trial launch, sampled only in IDLE; the same pulse drives the multipliers.
- `done`  input  `NUM_CH`: `productDone` from each copy; level or pulse.
- `busy`  output  1: high in RUN and REPORT.
- `timingLeakDone`  output  1: one-cycle pulse in REPORT.
- `timingLeak`  output  1: result of the last trial; 1 = latencies differ or timeout.
- `timeout`  output  1: last trial hit `TIMEOUT`.
- `latency`  output  `NUM_CH*CNT_W`: per-channel latency, channel i at bits [i*CNT_W +: CNT_W].
- `skew`  output  `CNT_W`: max − min latency of the last trial.
- `leakCount`  output  `CNT_W`: number of leaking trials since reset, saturating.

## Operation
- FSM states: IDLE, RUN, REPORT.
- **IDLE**
  - `start`=1 → RUN.
  - On entry to RUN: cycle counter `cyc` := 1, capture mask := 0, running min := all-ones, running max := 0.
  - `done` is ignored in IDLE.
- **RUN**, evaluated each cycle:
  - For every channel i with `done[i]`=1 and mask[i]=0: `latency[i]` := `cyc`, mask[i] := 1, update min/max with `cyc`.
  - Several channels may capture in the same cycle.
  - A `done` held high for several cycles is captured once, at its first RUN cycle.
  - If mask, including this cycle's captures, is all ones → REPORT.
  - Else if `cyc` == `TIMEOUT` → REPORT with the timeout flag set.
  - Else `cyc` += 1.
- **REPORT**, exactly one cycle, then IDLE:
  - Normal completion:
    - `timingLeak` = (max ≠ min).
    - `skew` = max − min.
    - `timeout` = 0.
  - Timeout:
    - `timeout` = 1, `timingLeak` = 1, `skew` = all-ones.
    - Uncaptured channels report `latency` = all-ones; captured channels keep their measured values.
  - `leakCount` increments if `timingLeak`=1; it saturates at all-ones.
- `start` in RUN or REPORT is ignored. It does not restart the trial and is not queued.
- `latency`, `skew`, `timingLeak` and `timeout` hold their values until the next trial completes. They are not cleared at trial start.
- Reset (`rst`=0 at an edge), in any state including mid-RUN:
  - State goes to IDLE.
  - `busy`, `timingLeakDone`, `timingLeak`, `timeout` = 0.
  - `latency`, `skew`, `leakCount` = 0.
  - The internal mask, min/max and `cyc` are cleared.

## Timing
- All outputs are registered. `timingLeakDone` and `busy` decode directly from the state register.
- `start` high at edge k (IDLE) → RUN from cycle k+1, with `cyc`=1 in that cycle.
- A `done` first sampled high in the j-th RUN cycle gives latency j. This equals the number of edges from the start edge to the done-sampling edge.
- If the last capture happens at `cyc`=L, REPORT occupies the next cycle:
  - `timingLeakDone` is high at cycle k+L+1.
  - `timingLeak`, `skew` and `latency` are valid in that cycle.
- On timeout, REPORT occupies cycle k+`TIMEOUT`+1.
- Back-to-back trials: earliest accepted `start` is in the IDLE cycle after REPORT, so the minimum trial period is L+2 cycles.

## Test plan
- **Equal latencies:** `NUM_CH`=4; after `start`, all `done` rise at `cyc`=5.
  - `timingLeakDone` pulses exactly one cycle, 6 cycles after the start edge.
  - `latency`={5,5,5,5}, `skew`=0, `timingLeak`=0, `leakCount`=0.
- **Mismatch:** channels 0, 1, 3 done at 5; channel 2 done at 7.
  - `latency[2]`=7, `skew`=2, `timingLeak`=1, `leakCount`=1.
  - Repeat the trial → `leakCount`=2.
- **Timeout:** `TIMEOUT`=16; channel 3 never asserts `done`; others at 4.
  - REPORT occurs 17 cycles after start, with `timeout`=1, `timingLeak`=1, `skew`=0xFFFF.
  - `latency[3]`=0xFFFF; the other channels read 4.
- **Ignored inputs:**
  - `done` high in IDLE before `start` is not captured.
  - A second `start` at `cyc`=2 is ignored.
  - `done` held high for 10 cycles records the first cycle only.
- **Reset mid-run:** drive `rst`=0 at `cyc`=3.
  - Next cycle: `busy`=0 and all outputs are 0.
  - A fresh trial with all done at 6 reports latency 6 everywhere and `leakCount`=0.
- **Simultaneous capture and saturation:** `CNT_W`=4 with the leak condition forced for 20 trials.
  - `leakCount` stops at 15.
  - All channels done in the first RUN cycle gives `latency`=1 for every channel and REPORT on the next cycle.
